// File: rtl/uart_rx_fifo_if.sv
// Receiver-side capture handshake plus host-side FWFT stream
// and FIFO status for uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_rdy_clr;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  logic          ovf_clr;

  modport slave (
    input  rx_rdy,
    input  rx_data,
    input  m_ready,
    input  ovf_clr,
    output rx_rdy_clr,
    output m_data,
    output m_valid,
    output count,
    output full,
    output overflow
  );

  modport master (
    output rx_rdy,
    output rx_data,
    output m_ready,
    output ovf_clr,
    input  rx_rdy_clr,
    input  m_data,
    input  m_valid,
    input  count,
    input  full,
    input  overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures rdy-flagged bytes, pulses rdy_clr,
// and serves them from a first-word-fall-through FIFO.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    WAIT = 2'd2
  } cap_e;

  cap_e          state_q;
  logic          clr_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          ovf_q;
  logic          ovf_d;

  logic          valid_w;
  logic          full_w;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;

  assign valid_w = (cnt_q != '0);
  assign full_w  = (cnt_q == FULL_CNT);
  assign push    = (state_q == IDLE) & bus.rx_rdy;
  assign pop     = valid_w & bus.m_ready;
  // A full FIFO still takes the byte if the head leaves on the same edge
  assign accept  = push & (~full_w | pop);
  assign drop    = push & ~accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_rdy) begin
            state_q <= CLR;
            clr_q   <= 1'b1;
          end
        end
        CLR: begin
          state_q <= WAIT;
          clr_q   <= 1'b0;
        end
        WAIT: begin
          clr_q <= 1'b0;
          if (!bus.rx_rdy) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          clr_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (accept & ~pop): cnt_d = cnt_q + 1'b1;
      (pop & ~accept): cnt_d = cnt_q - 1'b1;
      default:         cnt_d = cnt_q;
    endcase
  end

  // A new drop outranks a same-cycle clear
  assign ovf_d = drop | (ovf_q & ~bus.ovf_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= bus.rx_data;
  end

  assign bus.rx_rdy_clr = clr_q;
  assign bus.m_data     = mem_q[rd_q];
  assign bus.m_valid    = valid_w;
  assign bus.count      = cnt_q;
  assign bus.full       = full_w;
  assign bus.overflow   = ovf_q;
endmodule
